stream_seq_ctrl: RTL

STREAM_SEQ_CTRL -- requirements
Module: stream_seq_ctrl

---
 rtl/stream_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/stream_seq_ctrl.sv
// stream_seq_ctrl
//   Sequences one configuration/data packet arriving on a valid/ready stream.
//   Packet layout: header (cal_num in bits [31:0]), WEIGHT_NUM weight beats,
//   MAT_BEATS matrix beats, REF_NUM reference beats, LAY_NUM layer beats and
//   cal_num calibration points. Each accepted beat raises the strobe of its
//   phase. Each calibration point yields a label PIPE_LAT cycles later. After
//   the last beat the block drains the label pipeline and pulses done.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready  input beat stream (ready low only while draining)
//   ph_hdr .. ph_cal     one-hot phase write strobes (combinational, on handshake)
//   beat_idx             beat index within the current phase (low 8 bits)
//   cal_num              point count latched from the header
//   busy                 packet in progress (any state but IDLE)
//   m_tvalid, m_tlast    label valid / last label
//   done                 one-cycle end-of-packet pulse
//   err                  one-cycle watchdog pulse
//
// Build option
//   STREAM_TIMEOUT_EN    when defined, a watchdog aborts a packet after TIMEOUT
//                        consecutive cycles without a handshake in an input
//                        phase; otherwise err is tied low and the block waits.
module stream_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int WEIGHT_NUM = 57,
  parameter int MAT_BEATS  = 3,
  parameter int REF_NUM    = 43,
  parameter int LAY_NUM    = 5,
  parameter int PIPE_LAT   = 33,
  parameter int TIMEOUT    = 1024
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [LANES*DATA_WIDTH-1:0] s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic                        ph_hdr,
  output logic                        ph_weight,
  output logic                        ph_mat,
  output logic                        ph_ref,
  output logic                        ph_lay,
  output logic                        ph_cal,
  output logic [7:0]                  beat_idx,
  output logic [31:0]                 cal_num,
  output logic                        busy,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  output logic                        done,
  output logic                        err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WEIGHT = 3'd1,
    S_MAT    = 3'd2,
    S_REF    = 3'd3,
    S_LAY    = 3'd4,
    S_CAL    = 3'd5,
    S_DRAIN  = 3'd6
  } state_t;

  localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int PIPE_W  = 2 * PIPE_LAT;

  state_t               state_q, state_d;
  logic [31:0]          beat_q, beat_d;       // full-width so CAL can exceed 255 points
  logic [31:0]          cal_num_q, cal_num_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [PIPE_W-1:0]    pipe_q, pipe_d;       // PIPE_LAT stages of {valid,last}, newest in [1:0]
  logic                 done_q, done_d;

  logic                 hs_s;
  logic                 cal_stb_s;
  logic                 last_beat_s;
  state_t               next_phase_s;
  logic [1:0]           pipe_in_s;
  logic [PIPE_W+1:0]    pipe_shift_s;
  logic                 unused_tdata_s;

  assign s_tready  = (state_q != S_DRAIN);
  assign hs_s      = s_tvalid & s_tready;
  assign cal_stb_s = hs_s & (state_q == S_CAL);

  // Strobes are gated with the reset so nothing fires while aresetn is low.
  assign ph_hdr    = aresetn & hs_s & (state_q == S_IDLE);
  assign ph_weight = aresetn & hs_s & (state_q == S_WEIGHT);
  assign ph_mat    = aresetn & hs_s & (state_q == S_MAT);
  assign ph_ref    = aresetn & hs_s & (state_q == S_REF);
  assign ph_lay    = aresetn & hs_s & (state_q == S_LAY);
  assign ph_cal    = aresetn & cal_stb_s;

  assign beat_idx = beat_q[7:0];
  assign cal_num  = cal_num_q;
  assign busy     = (state_q != S_IDLE);
  assign m_tvalid = pipe_q[PIPE_W-1];
  assign m_tlast  = pipe_q[PIPE_W-2];
  assign done     = done_q;

  // Only the low 32 bits of the header carry information.
  assign unused_tdata_s = ^s_tdata;

  // Label pipeline input: a point is last when its index is cal_num-1.
  assign pipe_in_s    = {cal_stb_s, cal_stb_s & (beat_q == (cal_num_q - 32'd1))};
  assign pipe_shift_s = {pipe_q, pipe_in_s};

  // Phase length decode and successor phase.
  always_comb begin
    last_beat_s  = 1'b0;
    next_phase_s = S_IDLE;
    case (state_q)
      S_WEIGHT: begin
        last_beat_s  = (beat_q == 32'(WEIGHT_NUM - 1));
        next_phase_s = S_MAT;
      end
      S_MAT: begin
        last_beat_s  = (beat_q == 32'(MAT_BEATS - 1));
        next_phase_s = S_REF;
      end
      S_REF: begin
        last_beat_s  = (beat_q == 32'(REF_NUM - 1));
        next_phase_s = S_LAY;
      end
      S_LAY: begin
        last_beat_s  = (beat_q == 32'(LAY_NUM - 1));
        // An empty calibration set skips straight to draining.
        if (cal_num_q != 32'd0) begin
          next_phase_s = S_CAL;
        end else begin
          next_phase_s = S_DRAIN;
        end
      end
      S_CAL: begin
        last_beat_s  = (beat_q == (cal_num_q - 32'd1));
        next_phase_s = S_DRAIN;
      end
      default: begin
        last_beat_s  = 1'b0;
        next_phase_s = S_IDLE;
      end
    endcase
  end

`ifdef STREAM_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            in_phase_s;

  assign in_phase_s = (state_q == S_WEIGHT) || (state_q == S_MAT) || (state_q == S_REF) ||
                      (state_q == S_LAY) || (state_q == S_CAL);
  assign err        = err_q;
`else
  localparam int unused_timeout_s = TIMEOUT;
  assign err = 1'b0;
`endif

  // Next-state logic for the sequencer, drain counter and label pipeline.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    cal_num_d = cal_num_q;
    drain_d   = drain_q;
    done_d    = 1'b0;
    pipe_d    = pipe_shift_s[PIPE_W-1:0];
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          cal_num_d = s_tdata[31:0];
          beat_d    = 32'd0;
          state_d   = S_WEIGHT;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_WEIGHT, S_MAT, S_REF, S_LAY, S_CAL: begin
        if (hs_s && last_beat_s) begin
          beat_d  = 32'd0;
          state_d = next_phase_s;
        end else if (hs_s) begin
          beat_d  = beat_q + 32'd1;
        end else begin
          beat_d  = beat_q;
        end
      end
      S_DRAIN: begin
        // Final drain cycle is the one where the last label is visible.
        if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
          drain_d = {DRAIN_W{1'b0}};
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef STREAM_TIMEOUT_EN
    err_d = 1'b0;
    wd_d  = {WD_W{1'b0}};
    if (in_phase_s && !hs_s) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        beat_d  = 32'd0;
        pipe_d  = {PIPE_W{1'b0}};
      end else begin
        wd_d    = wd_q + WD_W'(1);
      end
    end else begin
      wd_d = {WD_W{1'b0}};
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      beat_q    <= 32'd0;
      cal_num_q <= 32'd0;
      drain_q   <= {DRAIN_W{1'b0}};
      pipe_q    <= {PIPE_W{1'b0}};
      done_q    <= 1'b0;
`ifdef STREAM_TIMEOUT_EN
      wd_q      <= {WD_W{1'b0}};
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      cal_num_q <= cal_num_d;
      drain_q   <= drain_d;
      pipe_q    <= pipe_d;
      done_q    <= done_d;
`ifdef STREAM_TIMEOUT_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule
